// File: rtl/regs_dbg_pkg.sv
// Shared types for the debug-port arbiter and the register file it feeds.
package regs_dbg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        RESP = 2'd2
    } dbg_state_t;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } dbg_req_t;

endpackage

// File: rtl/regs_dbg_starve_cnt.sv
// Saturating count of cycles a debug write has been blocked by core writeback,
// plus the registered stall request raised when the count hits the limit.
module regs_dbg_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic blocked,
    input  logic clear,
    output logic stall_req
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             stall_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_reg <= '0;
            stall_reg    <= 1'b0;
        end else if (clear) begin
            wait_cnt_reg <= '0;
            stall_reg    <= 1'b0;
        end else if (blocked && wait_cnt_reg != LIMIT) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            // Stall rises on the same edge the count reaches the limit.
            if (wait_cnt_reg + CNT_W'(1) == LIMIT)
                stall_reg <= 1'b1;
        end
    end

    assign stall_req = stall_reg;

endmodule

// File: rtl/regs_dbg_arbiter.sv
// Arbitrates single-outstanding debug reads/writes onto the register file's
// debug port; core writeback always wins the write port.
module regs_dbg_arbiter
    import regs_dbg_pkg::*;
#(
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int DATA_W       = REG_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    input  logic              core_wen_i,
    output logic              rf_en_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              stall_req_o,
    output logic              busy_o
);

    dbg_state_t        state_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic in_arb;
    logic blocked;
    logic leave_arb;

    assign in_arb    = (state_reg == ARB);
    assign blocked   = in_arb && we_reg && core_wen_i;
    assign leave_arb = in_arb && !blocked;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        we_reg    <= req_we_i;
                        addr_reg  <= req_addr_i;
                        wdata_reg <= req_wdata_i;
                        state_reg <= ARB;
                    end
                end
                ARB: begin
                    // Reads never contend for the write port, so they finish at once.
                    if (!we_reg) begin
                        rdata_reg <= rf_rdata_i;
                        state_reg <= RESP;
                    end else if (!core_wen_i) begin
                        rdata_reg <= '0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    regs_dbg_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .blocked  (blocked),
        .clear    (leave_arb),
        .stall_req(stall_req_o)
    );

    // The enable is decoded from state so a reset can never leave a half-issued write.
    assign rf_en_o     = in_arb && we_reg && !core_wen_i;
    assign rf_addr_o   = in_arb ? addr_reg  : '0;
    assign rf_wdata_o  = in_arb ? wdata_reg : '0;
    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_rdata_o = rdata_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_regs_dbg_arbiter.sv
// Directed bench for regs_dbg_arbiter with a register-file model and a
// response scoreboard.
module tb_regs_dbg_arbiter;
    import regs_dbg_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        core_wen_i;
    logic        rf_en_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] rf_rdata_i;
    logic        stall_req_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int inv_err = 0;

    logic [31:0] rf_mem [32];
    logic [31:0] shadow [32];
    dbg_req_t    sb_q [$];

    always #5 clk_i = ~clk_i;

    regs_dbg_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .core_wen_i(core_wen_i),
        .rf_en_o(rf_en_o), .rf_addr_o(rf_addr_o), .rf_wdata_o(rf_wdata_o),
        .rf_rdata_i(rf_rdata_i),
        .stall_req_o(stall_req_o), .busy_o(busy_o)
    );

    // Register-file model: address 0 is hard-wired to zero.
    assign rf_rdata_i = (rf_addr_o == 5'd0) ? 32'd0 : rf_mem[rf_addr_o];
    always @(posedge clk_i) begin
        if (rf_en_o && rf_addr_o != 5'd0) rf_mem[rf_addr_o] <= rf_wdata_o;
        if (rf_en_o) en_cnt <= en_cnt + 1;
        if (rf_en_o && core_wen_i) inv_err <= inv_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for a single edge; the DUT must be idle.
    task automatic issue(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        dbg_req_t r;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
        #1;
        check("accept_ready", {31'd0, req_ready_o}, 32'd1);
        r.we = we; r.addr = addr; r.wdata = wdata;
        sb_q.push_back(r);
        tick();
        req_valid_i = 1'b0;
        $display("req we=%0d addr=%0d wdata=%h", we, addr, wdata);
    endtask

    // Wait (bounded) for a response, compare against scoreboard, then handshake.
    task automatic wait_rsp(input string tag);
        int n = 0;
        dbg_req_t r;
        logic [31:0] exp;
        while (!rsp_valid_o && n < 20) begin tick(); n++; end
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            r = sb_q.pop_front();
            exp = r.we ? 32'd0 : shadow[r.addr];
            check({tag, "_rdata"}, rsp_rdata_o, exp);
            if (r.we && r.addr != 5'd0) shadow[r.addr] = r.wdata;
            $display("rsp %s addr=%0d rdata=%h exp=%h", tag, r.addr, rsp_rdata_o, exp);
        end
        rsp_ready_i = 1'b1;
        tick();
    endtask

    initial begin
        int en0;
        logic [31:0] held;
        for (int i = 0; i < 32; i++) begin rf_mem[i] = 32'd0; shadow[i] = 32'd0; end
        rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0;
        rsp_ready_i = 1'b1; core_wen_i = 1'b0;
        #2;
        check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_rf_en", {31'd0, rf_en_o}, 32'd0);
        check("rst_rf_addr", {27'd0, rf_addr_o}, 32'd0);
        check("rst_rf_wdata", rf_wdata_o, 32'd0);
        check("rst_stall", {31'd0, stall_req_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);

        // Uncontended write: rf_en in cycle 1, response in cycle 2.
        issue(1'b1, 5'd5, 32'hDEADBEEF);
        check("w5_rf_en_c1", {31'd0, rf_en_o}, 32'd1);
        check("w5_rf_addr", {27'd0, rf_addr_o}, 32'd5);
        check("w5_rf_wdata", rf_wdata_o, 32'hDEADBEEF);
        check("w5_rdy_c1", {31'd0, req_ready_o}, 32'd0);
        tick();
        check("w5_rf_en_c2", {31'd0, rf_en_o}, 32'd0);
        check("w5_rsp_c2", {31'd0, rsp_valid_o}, 32'd1);
        wait_rsp("w5");
        issue(1'b0, 5'd5, 32'd0);
        wait_rsp("r5");

        // Write blocked for two cycles, issues on the third ARB cycle.
        core_wen_i = 1'b1;
        issue(1'b1, 5'd3, 32'h0000_3333);
        check("w3_blk1", {31'd0, rf_en_o}, 32'd0);
        tick();
        check("w3_blk2", {31'd0, rf_en_o}, 32'd0);
        tick();
        core_wen_i = 1'b0; #1;
        check("w3_en_c3", {31'd0, rf_en_o}, 32'd1);
        check("w3_stall", {31'd0, stall_req_o}, 32'd0);
        wait_rsp("w3");
        check("w3_stall_after", {31'd0, stall_req_o}, 32'd0);

        // Starvation: stall rises after 4 blocked cycles, clears on leaving ARB.
        core_wen_i = 1'b1;
        issue(1'b1, 5'd9, 32'h1234_5678);
        tick(); tick(); tick();
        check("w9_stall_c3", {31'd0, stall_req_o}, 32'd0);
        tick();
        check("w9_stall_c4", {31'd0, stall_req_o}, 32'd1);
        tick();
        check("w9_stall_hold", {31'd0, stall_req_o}, 32'd1);
        en0 = en_cnt;
        core_wen_i = 1'b0; #1;
        check("w9_rf_en", {31'd0, rf_en_o}, 32'd1);
        tick();
        check("w9_stall_clr", {31'd0, stall_req_o}, 32'd0);
        check("w9_one_pulse", en_cnt - en0, 32'd1);
        wait_rsp("w9");

        // Reads ignore core writeback.
        issue(1'b1, 5'd7, 32'hA5A5_0007);
        wait_rsp("w7");
        core_wen_i = 1'b1;
        issue(1'b0, 5'd7, 32'd0);
        check("r7_no_rf_en", {31'd0, rf_en_o}, 32'd0);
        tick();
        check("r7_rsp_now", {31'd0, rsp_valid_o}, 32'd1);
        wait_rsp("r7");
        issue(1'b0, 5'd0, 32'd0);
        wait_rsp("r0");
        core_wen_i = 1'b0;
        issue(1'b1, 5'd0, 32'hFFFF_FFFF);
        wait_rsp("w0");
        issue(1'b0, 5'd0, 32'd0);
        wait_rsp("r0b");

        // Response back-pressure: output stable, no new acceptance.
        rsp_ready_i = 1'b0;
        issue(1'b0, 5'd9, 32'd0);
        tick();
        held = rsp_rdata_o;
        check("bp_rdata", held, 32'h1234_5678);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 5'd3; req_wdata_i = 32'hCAFE_0003;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("bp_stable", rsp_rdata_o, held);
            check("bp_not_ready", {31'd0, req_ready_o}, 32'd0);
        end
        wait_rsp("r9_bp");
        // Pending request is accepted on the edge after the handshake.
        check("bp_accept_now", {31'd0, req_ready_o}, 32'd1);
        begin
            dbg_req_t r;
            r.we = 1'b1; r.addr = 5'd3; r.wdata = 32'hCAFE_0003;
            sb_q.push_back(r);
        end
        tick();
        req_valid_i = 1'b0;
        wait_rsp("w3b");
        issue(1'b0, 5'd3, 32'd0);
        wait_rsp("r3b");

        // Async reset during a starved write.
        core_wen_i = 1'b1;
        issue(1'b1, 5'd4, 32'h4444_4444);
        tick(); tick(); tick(); tick();
        check("rst_pre_stall", {31'd0, stall_req_o}, 32'd1);
        en0 = en_cnt;
        #2 rst_i = 1'b1;
        #1;
        check("arst_stall", {31'd0, stall_req_o}, 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_ready", {31'd0, req_ready_o}, 32'd1);
        check("arst_rf_en", {31'd0, rf_en_o}, 32'd0);
        check("arst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        void'(sb_q.pop_back());
        core_wen_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick(); tick(); tick();
        check("arst_no_pulse", en_cnt - en0, 32'd0);
        check("arst_idle", {31'd0, busy_o}, 32'd0);
        issue(1'b0, 5'd4, 32'd0);
        wait_rsp("r4_after_rst");

        check("inv_rf_en_vs_core", inv_err, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
